// File: rtl/fat32_pkg.sv
// Shared FAT32 definitions: controller states, 8.3 directory-entry layout,
// and the byte generator for a freshly written entry.
package fat32_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    PRIME,
    READY,
    EMIT
  } dir_wr_state_e;

  localparam int unsigned DIR_ENTRY_BYTES = 32;

  localparam logic [4:0] OFF_NAME    = 5'd0;
  localparam logic [4:0] OFF_EXT     = 5'd8;
  localparam logic [4:0] OFF_ATTR    = 5'd11;
  localparam logic [4:0] OFF_CLUS_HI = 5'd20;
  localparam logic [4:0] OFF_CLUS_LO = 5'd26;
  localparam logic [4:0] OFF_SIZE    = 5'd28;

  localparam logic [7:0] SLOT_FREE    = 8'h00;
  localparam logic [7:0] SLOT_DELETED = 8'hE5;

  // Byte at entry offset 'off'; multi-byte numeric fields are little-endian.
  function automatic logic [7:0] entry_byte(
    input logic [4:0]  off,
    input logic [63:0] name,
    input logic [23:0] ext,
    input logic [7:0]  attr,
    input logic [31:0] clus,
    input logic [31:0] size
  );
    logic [63:0] name_sh;
    logic [23:0] ext_sh;
    logic [31:0] size_sh;
    name_sh = name << {off[2:0], 3'b000};
    ext_sh  = ext << {off[1:0], 3'b000};
    size_sh = size >> {off[1:0], 3'b000};
    entry_byte = 8'h00;
    if (off < OFF_EXT)                          entry_byte = name_sh[63:56];
    else if (off < OFF_ATTR)                    entry_byte = ext_sh[23:16];
    else if (off == OFF_ATTR)                   entry_byte = attr;
    else if (off == OFF_CLUS_HI)                entry_byte = clus[23:16];
    else if (off == OFF_CLUS_HI + 5'd1)         entry_byte = clus[31:24];
    else if (off == OFF_CLUS_LO)                entry_byte = clus[7:0];
    else if (off == OFF_CLUS_LO + 5'd1)         entry_byte = clus[15:8];
    else if (off >= OFF_SIZE)                   entry_byte = size_sh[7:0];
  endfunction

endpackage

// File: rtl/fat32_dir_entry_writer_sector_buffer.sv
// Single-port sector RAM, synchronous write and registered (read-first) output.
module sector_buffer #(
  parameter  int unsigned DEPTH  = 512,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/fat32_dir_entry_writer.sv
// Captures a root-directory sector during READ, then replays it during WRITE
// with a new 8.3 entry substituted into the chosen slot.
module fat32_dir_entry_writer
  import fat32_pkg::*;
#(
  parameter int unsigned SECTOR_BYTES = 512,
  parameter logic [7:0]  ENTRY_ATTR   = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] filename,
  input  logic [23:0] extension,
  input  logic [31:0] file_size,
  input  logic [31:0] first_cluster,
  input  logic [3:0]  entry_slot,
  input  logic [7:0]  sd_incoming_byte,
  input  logic        sd_finished_byte,
  input  logic        sd_finished_block,
  output logic [7:0]  sd_outgoing_byte,
  output logic        busy,
  output logic        ready_to_emit,
  output logic        done,
  output logic        error
);

  localparam int unsigned      CNT_W  = $clog2(SECTOR_BYTES) + 1;
  localparam int unsigned      ADDR_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(SECTOR_BYTES);

  dir_wr_state_e     state;
  logic [CNT_W-1:0]  cnt, cnt_inc, cnt_post, slot_base;
  logic [63:0]       name_q;
  logic [23:0]       ext_q;
  logic [31:0]       size_q, clus_q;
  logic [3:0]        slot_q;
  logic              occupied, out_en;
  logic [ADDR_W-1:0] cur_addr, ram_addr;
  logic [7:0]        ram_rdata, patched;
  logic              cap_we, emit_step, rd_step, slot_hit, in_window;

  always_comb begin
    cnt_inc   = (cnt == FULL) ? cnt : cnt + 1'b1;
    slot_base = CNT_W'({slot_q, 5'b00000});
    cap_we    = (state == CAPTURE) && sd_finished_byte && (cnt != FULL);
    emit_step = ((state == READY) || (state == EMIT)) && sd_finished_byte && (cnt != FULL);
    rd_step   = emit_step && (cnt_inc != FULL);
    cnt_post  = (cap_we || emit_step) ? cnt_inc : cnt;
    slot_hit  = cap_we && (cnt == slot_base) &&
                (sd_incoming_byte != SLOT_FREE) && (sd_incoming_byte != SLOT_DELETED);
    // During replay the RAM address advances on the consume pulse itself, so
    // the next byte appears one cycle later; otherwise it holds the last read.
    ram_addr = cur_addr;
    if (state == CAPTURE)    ram_addr = cnt[ADDR_W-1:0];
    else if (state == PRIME) ram_addr = '0;
    else if (rd_step)        ram_addr = cnt_inc[ADDR_W-1:0];
  end

  sector_buffer #(.DEPTH(SECTOR_BYTES)) u_buf (
    .clk   (clk),
    .we    (cap_we),
    .addr  (ram_addr),
    .wdata (sd_incoming_byte),
    .rdata (ram_rdata)
  );

  // cur_addr is the address whose data sits in ram_rdata this cycle.
  always_comb begin
    in_window = (cur_addr[ADDR_W-1:5] == slot_q);
    patched   = in_window ? entry_byte(cur_addr[4:0], name_q, ext_q, ENTRY_ATTR, clus_q, size_q)
                          : ram_rdata;
    sd_outgoing_byte = out_en ? patched : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      cur_addr      <= '0;
      occupied      <= 1'b0;
      out_en        <= 1'b0;
      busy          <= 1'b0;
      ready_to_emit <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      done     <= 1'b0;
      cur_addr <= ram_addr;
      case (state)
        IDLE: if (start) begin
          name_q   <= filename;
          ext_q    <= extension;
          size_q   <= file_size;
          clus_q   <= first_cluster;
          slot_q   <= entry_slot;
          error    <= 1'b0;
          cnt      <= '0;
          occupied <= 1'b0;
          out_en   <= 1'b0;
          busy     <= 1'b1;
          state    <= CAPTURE;
        end
        CAPTURE: begin
          if (cap_we) cnt <= cnt_inc;
          if (slot_hit) occupied <= 1'b1;
          if (sd_finished_block) begin
            if ((cnt_post != FULL) || occupied || slot_hit) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              cnt   <= '0;
              state <= PRIME;
            end
          end
        end
        PRIME: begin
          out_en        <= 1'b1;
          ready_to_emit <= 1'b1;
          state         <= READY;
        end
        READY: if (sd_finished_byte) begin
          cnt           <= cnt_inc;
          ready_to_emit <= 1'b0;
          state         <= EMIT;
        end
        EMIT: begin
          if (emit_step) cnt <= cnt_inc;
          if (sd_finished_block) begin
            if (cnt_post == FULL) done <= 1'b1;
            else                  error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fat32_dir_entry_writer.sv
// Directed + randomized bench for the FAT32 directory-entry writer.
module tb_fat32_dir_entry_writer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [63:0] filename;
  logic [23:0] extension;
  logic [31:0] file_size, first_cluster;
  logic [3:0]  entry_slot;
  logic [7:0]  sd_incoming_byte;
  logic        sd_finished_byte, sd_finished_block;
  logic [7:0]  sd_outgoing_byte;
  logic        busy, ready_to_emit, done, error;

  int total = 0;
  int bad   = 0;

  logic [7:0]  sector [512];
  logic [7:0]  expb   [512];
  logic [7:0]  hello_e [32];
  logic [63:0] fname;
  logic [23:0] fext;
  logic [31:0] fsize, fclus;
  int          fslot;

  always #5 clk = ~clk;

  fat32_dir_entry_writer #(.SECTOR_BYTES(512), .ENTRY_ATTR(8'h20)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .filename          (filename),
    .extension         (extension),
    .file_size         (file_size),
    .first_cluster     (first_cluster),
    .entry_slot        (entry_slot),
    .sd_incoming_byte  (sd_incoming_byte),
    .sd_finished_byte  (sd_finished_byte),
    .sd_finished_block (sd_finished_block),
    .sd_outgoing_byte  (sd_outgoing_byte),
    .busy              (busy),
    .ready_to_emit     (ready_to_emit),
    .done              (done),
    .error             (error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the 32-byte entry laid out field by field.
  function automatic logic [7:0] model_entry(input int o);
    if (o < 8)   return 8'(fname >> (8 * (7 - o)));
    if (o < 11)  return 8'(fext >> (8 * (10 - o)));
    if (o == 11) return 8'h20;
    if (o == 20) return 8'(fclus >> 16);
    if (o == 21) return 8'(fclus >> 24);
    if (o == 26) return 8'(fclus);
    if (o == 27) return 8'(fclus >> 8);
    if (o >= 28) return 8'(fsize >> (8 * (o - 28)));
    return 8'h00;
  endfunction

  task automatic build_expected();
    for (int a = 0; a < 512; a++)
      expb[a] = (a / 32 == fslot) ? model_entry(a % 32) : sector[a];
  endtask

  task automatic rand_setup(input int slot, input logic [7:0] marker);
    fname = {$urandom, $urandom};
    fext  = 24'($urandom);
    fsize = $urandom;
    fclus = $urandom;
    fslot = slot;
    for (int i = 0; i < 512; i++) sector[i] = 8'($urandom);
    sector[slot * 32] = marker;
    build_expected();
  endtask

  task automatic do_start();
    filename      = fname;
    extension     = fext;
    file_size     = fsize;
    first_cluster = fclus;
    entry_slot    = 4'(fslot);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic capture(input int n, input bit block_on_last);
    for (int i = 0; i < n; i++) begin
      sd_incoming_byte = sector[i];
      sd_finished_byte = 1'b1;
      if (block_on_last && i == n - 1) sd_finished_block = 1'b1;
      @(negedge clk);
      sd_finished_byte  = 1'b0;
      sd_finished_block = 1'b0;
      @(negedge clk);
    end
    if (!block_on_last) begin
      sd_finished_block = 1'b1;
      @(negedge clk);
      sd_finished_block = 1'b0;
    end
  endtask

  task automatic emit(input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("emit[%0d]", i), 32'(sd_outgoing_byte), 32'(expb[i]));
      sd_finished_byte = 1'b1;
      @(negedge clk);
      sd_finished_byte = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic finish_emit();
    sd_finished_block = 1'b1;
    @(negedge clk);
    sd_finished_block = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_no_error", 32'(error), 32'd0);
    chk("done_busy_low", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic expect_ready(input string tag);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(ready_to_emit), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic full_run(input string tag);
    do_start();
    capture(512, 1'b0);
    expect_ready(tag);
    emit(512);
    finish_emit();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    hello_e = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h20, 8'h20,
                8'h54, 8'h58, 8'h54, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h05, 8'h00, 8'h34, 8'h12, 8'h00, 8'h00};
    reset = 1'b1; start = 1'b0;
    filename = '0; extension = '0; file_size = '0; first_cluster = '0; entry_slot = '0;
    sd_incoming_byte = '0; sd_finished_byte = 1'b0; sd_finished_block = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready_to_emit), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_out", 32'(sd_outgoing_byte), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Free slot 3 with the fixed HELLO.TXT entry
    fname = 64'h48454C4C4F202020; fext = 24'h545854;
    fsize = 32'h00001234; fclus = 32'h00010005; fslot = 3;
    for (int i = 0; i < 512; i++) begin
      sector[i] = 8'(i);
      expb[i]   = 8'(i);
    end
    for (int k = 0; k < 32; k++) begin
      sector[96 + k] = 8'h00;
      expb[96 + k]   = hello_e[k];
    end
    do_start();
    chk("hello_busy", 32'(busy), 32'd1);
    capture(512, 1'b0);
    expect_ready("hello");
    emit(512);
    finish_emit();

    // Occupied slot 0
    rand_setup(0, 8'h41);
    do_start();
    capture(512, 1'b0);
    chk("occ_error", 32'(error), 32'd1);
    chk("occ_busy", 32'(busy), 32'd0);
    chk("occ_ready", 32'(ready_to_emit), 32'd0);
    @(negedge clk);
    chk("occ_ready_later", 32'(ready_to_emit), 32'd0);

    // Deleted slot 15 reuse
    rand_setup(15, 8'hE5);
    full_run("deleted");

    // Short block, then restart with simultaneous last byte / block end
    rand_setup(int'($urandom_range(0, 15)), 8'h00);
    do_start();
    chk("short_err_cleared_at_start", 32'(error), 32'd0);
    capture(300, 1'b0);
    chk("short_error", 32'(error), 32'd1);
    chk("short_busy", 32'(busy), 32'd0);
    do_start();
    chk("restart_error_clear", 32'(error), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    capture(512, 1'b1);
    expect_ready("simul");
    emit(512);
    chk("hold_last", 32'(sd_outgoing_byte), 32'(expb[511]));
    sd_finished_byte = 1'b1;
    @(negedge clk);
    sd_finished_byte = 1'b0;
    @(negedge clk);
    chk("hold_after_extra", 32'(sd_outgoing_byte), 32'(expb[511]));
    finish_emit();

    // Reset at byte 200 of EMIT, then a clean run
    rand_setup(int'($urandom_range(0, 15)), ($urandom_range(0, 1) != 0) ? 8'hE5 : 8'h00);
    do_start();
    capture(512, 1'b0);
    expect_ready("pre_reset");
    emit(200);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out", 32'(sd_outgoing_byte), 32'd0);
    chk("midrst_ready", 32'(ready_to_emit), 32'd0);
    chk("midrst_error", 32'(error), 32'd0);
    rand_setup(int'($urandom_range(0, 15)), 8'h00);
    full_run("post_reset");

    // Randomized slots, markers and fields
    for (int r = 0; r < 3; r++) begin
      rand_setup(int'($urandom_range(0, 15)), ($urandom_range(0, 1) != 0) ? 8'hE5 : 8'h00);
      full_run($sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fat32_dir_entry_writer.md
Name: fat32_dir_entry_writer

Overview:
Write-side partner to the FAT32 read path. It captures one 512-byte root-directory sector as the SD card controller streams it in during a READ. It then patches a new 32-byte 8.3 directory entry into a chosen slot. During the following WRITE it supplies the patched sector back, byte by byte, on the SD controller's outgoing_byte input. It sits between the FAT32 controller FSM and the sd_card_controller byte interface.

Parameters:
SECTOR_BYTES, 512, bytes per sector; the byte counter is clog2(SECTOR_BYTES) + 1 bits wide.
ENTRY_ATTR, 8'h20, attribute byte written at entry offset 11 (archive).

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; latches the entry fields and slot, enters CAPTURE
filename  in  64  8-char name; [63:56] is the first character
extension  in  24  3-char extension; [23:16] is the first character
file_size  in  32  file size in bytes
first_cluster  in  32  first cluster number of the file
entry_slot  in  4  slot 0..15 within the sector (byte offset = slot*32)
sd_incoming_byte  in  8  read data from the SD controller
sd_finished_byte  in  1  one-cycle pulse per byte transferred (read or write)
sd_finished_block  in  1  one-cycle pulse at end of a 512-byte block
sd_outgoing_byte  out  8  byte presented to the SD controller for WRITE
busy  out  1  high in any state other than IDLE
ready_to_emit  out  1  high in READY (sector captured and slot free)
done  out  1  one-cycle pulse when the emit block completes
error  out  1  sticky; cleared by the next start or by reset

Behaviour:
- Reset values: busy, ready_to_emit, done and error are 0; sd_outgoing_byte is 8'h00; state is IDLE; byte counter is 0.
- IDLE:
  - A start pulse latches the fields, clears error and the counter, and moves to CAPTURE.
  - A start pulse outside IDLE is ignored.
- CAPTURE:
  - Each sd_finished_byte writes sd_incoming_byte into buffer[counter], then increments the counter.
  - Pulses after 512 bytes are ignored; the counter saturates at 512.
  - The byte at offset slot*32+0 is checked when it arrives. Any value other than 8'h00 or 8'hE5 sets the occupied flag.
  - When sd_finished_block arrives:
    - counter != 512 -> error=1, go to IDLE.
    - occupied -> error=1, go to IDLE.
    - otherwise clear the counter and go to PRIME.
  - If sd_finished_byte and sd_finished_block assert in the same cycle, the byte is stored first; the counter check uses the post-increment value.
- PRIME:
  - One cycle issuing the buffer read of address 0.
  - Next cycle: sd_outgoing_byte = patched byte 0; go to READY.
- READY:
  - ready_to_emit=1. The parent starts the SD WRITE.
  - The first sd_finished_byte moves to EMIT and counts as byte 0 consumed.
- EMIT:
  - Each sd_finished_byte increments the counter and issues a read of the next address.
  - sd_outgoing_byte updates with the patched byte exactly 1 cycle after the pulse. The SD controller must not sample faster than 2 cycles per byte.
  - Pulses past 512 are ignored; the last byte is held.
  - When sd_finished_block arrives:
    - counter == 512 -> done pulse for 1 cycle, go to IDLE.
    - otherwise error=1, go to IDLE.
- Patch mux: for addresses inside the slot window [slot*32, slot*32+31], output these instead of buffer data (entry offset o):
  - o 0..7: filename bytes, MSB first.
  - o 8..10: extension bytes, MSB first.
  - o 11: ENTRY_ATTR.
  - o 12..19: 0.
  - o 20..21: first_cluster[23:16], then [31:24] (little-endian high word).
  - o 22..25: 0.
  - o 26..27: first_cluster[7:0], then [15:8].
  - o 28..31: file_size, LSB first.
  - Outside the window, output buffer data unchanged.
- reset mid-operation: return to IDLE with all outputs at reset values. Buffer contents are don't-care.

Decomposition:
- Shared package fat32_pkg holds:
  - the state enum (IDLE, CAPTURE, PRIME, READY, EMIT);
  - DIR_ENTRY_BYTES=32;
  - entry field offsets (NAME=0, EXT=8, ATTR=11, CLUS_HI=20, CLUS_LO=26, SIZE=28);
  - the free-slot markers 8'h00 and 8'hE5.
- The FAT32 controller will also use this package.
- Sub-module sector_buffer: 512x8 single-port synchronous RAM with registered read (1-cycle latency) and write-enable.

Test Plan:
- Free slot patch: capture 512 bytes of pattern i[7:0] with slot 3 bytes all 00. Use filename "HELLO   ", ext "TXT", size 32'h00001234, cluster 32'h00010005. Emit must return the pattern everywhere except 96..127. Those bytes must be 48 45 4C 4C 4F 20 20 20 54 58 54 20 00×8 01 00 00×4 05 00 34 12 00 00. done pulses once.
- Occupied slot: slot 0 byte 0 = 8'h41 -> error=1 after finished_block, ready_to_emit never asserts, busy drops.
- Deleted slot reuse: slot 15 byte 0 = 8'hE5 -> accepted; bytes 480..511 are patched.
- Short block: finished_block after 300 bytes in CAPTURE -> error=1, state IDLE. A following start clears error.
- Simultaneous last byte and block end in CAPTURE; 513th byte pulse in EMIT -> capture succeeds; extra pulse ignored; done still pulses.
- Reset asserted mid-EMIT at byte 200 -> next cycle busy=0, sd_outgoing_byte=00. A new start/capture/emit completes normally.
